// File: rtl/proc_fetch.sv
// ---------------------------------------------------------------------------
// proc_fetch -- instruction fetch stage with a small in-order fetch buffer.
//
// Issues sequential fetch requests starting at RESET_PC and stores returned
// words, each with its PC, in a buffer. Decode consumes from the head of that
// buffer. A redirect flushes the buffer and restarts fetch at redirect_pc.
// Responses to requests issued before the redirect are still counted as
// in flight, but they are discarded when they return.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   redirect_val/_pc         squash everything and refetch from redirect_pc
//   stall_D                  decode holds its current instruction
//   imemreq_val/_rdy/_addr   fetch request handshake, address = pc_F
//   imemresp_val/_data       in-order instruction return, latency >= 1
//   val_D, inst_D, pc_D      head of the fetch buffer presented to decode
// ---------------------------------------------------------------------------
module proc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0200,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  input  logic        stall_D,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  output logic        val_D,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Credit limit, one bit wider than the counters so inflight+count never wraps.
  localparam logic [CW:0] CAP = (CW+1)'(BUF_DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] pc_f_q, pc_f_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_q, drop_d;
  cnt_t        count_q, count_d;
  ptr_t        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  ptr_t        head_q, head_d, tail_q, tail_d;

  logic [31:0] tag_mem [BUF_DEPTH];
  entry_t      buf_mem [BUF_DEPTH];

  logic accept;
  logic resp_keep;
  logic pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and buffer-head outputs. Credit uses registered counts only, so
  // a pop in this cycle does not open a request slot until the next cycle.
  always_comb begin
    imemreq_val  = !rst && !redirect_val &&
                   (({1'b0, inflight_q} + {1'b0, count_q}) < CAP);
    imemreq_addr = pc_f_q;
    accept       = imemreq_val && imemreq_rdy;
    resp_keep    = imemresp_val && !redirect_val && (drop_q == '0);
    val_D        = (count_q != '0);
    pop          = val_D && !stall_D && !redirect_val;
    inst_D       = buf_mem[head_q].inst;
    pc_D         = buf_mem[head_q].pc;
  end

  // NOTE: every next-state signal takes its hold value first, so no path
  // through this block leaves a variable unassigned (no latch inferred).
  always_comb begin
    pc_f_d     = pc_f_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (accept) begin
      pc_f_d   = pc_f_q + 32'd4;
      tag_wr_d = ptr_inc(tag_wr_q);
    end

    // Every response retires one in-flight request, dropped or not.
    if (accept && !imemresp_val) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!accept && imemresp_val) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (resp_keep) begin
      tag_rd_d = ptr_inc(tag_rd_q);
      tail_d   = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end

    if (resp_keep && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!resp_keep && pop) begin
      count_d = count_q - CW'(1);
    end

    if (imemresp_val && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    // A redirect cannot coincide with an accept (imemreq_val is low), so
    // everything still in flight after this edge belongs to the old stream.
    if (redirect_val) begin
      pc_f_d   = redirect_pc;
      drop_d   = imemresp_val ? (inflight_q - CW'(1)) : inflight_q;
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q     <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      pc_f_q     <= pc_f_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and counters decide
  // which slots are valid, so stale contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr_q] <= pc_f_q;
    end
    if (resp_keep) begin
      buf_mem[tail_q] <= '{inst: imemresp_data, pc: tag_mem[tag_rd_q]};
    end
  end

endmodule

// File: tb/tb_proc_fetch.sv
// ---------------------------------------------------------------------------
// tb_proc_fetch -- self-checking bench for proc_fetch.
//
// The reference model works at the level of streams: each redirect (or reset)
// starts a new epoch, fetch addresses of an epoch are consecutive words, and
// decode must see exactly that word stream in order with the matching memory
// contents. Memory is a queue of accepted requests, each with a due cycle.
// Responses to requests of an older epoch (or arriving in a redirect cycle)
// are expected to vanish. Two DUT instances share all inputs; `sel` chooses
// which one is checked (the second uses a reset PC that wraps at 2^32).
// ---------------------------------------------------------------------------
module tb_proc_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] PC_A  = 32'h0000_0200;
  localparam logic [31:0] PC_B  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        stall_D;
  logic        imemreq_rdy;
  logic        imemresp_val;
  logic [31:0] imemresp_data;

  logic        a_rv, b_rv, a_vd, b_vd;
  logic [31:0] a_addr, b_addr, a_inst, b_inst, a_pc, b_pc;

  logic        sel;
  logic        o_rv, o_vd;
  logic [31:0] o_addr, o_inst, o_pc;

  always #5 clk = ~clk;

  proc_fetch #(.RESET_PC(PC_A), .BUF_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc), .stall_D(stall_D),
    .imemreq_val(a_rv), .imemreq_rdy(imemreq_rdy), .imemreq_addr(a_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .val_D(a_vd), .inst_D(a_inst), .pc_D(a_pc)
  );

  proc_fetch #(.RESET_PC(PC_B), .BUF_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc), .stall_D(stall_D),
    .imemreq_val(b_rv), .imemreq_rdy(imemreq_rdy), .imemreq_addr(b_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .val_D(b_vd), .inst_D(b_inst), .pc_D(b_pc)
  );

  assign o_rv   = sel ? b_rv   : a_rv;
  assign o_vd   = sel ? b_vd   : a_vd;
  assign o_addr = sel ? b_addr : a_addr;
  assign o_inst = sel ? b_inst : a_inst;
  assign o_pc   = sel ? b_pc   : a_pc;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] fetch_pc;     // next address the fetch stream must request
  logic [31:0] head_pc;      // PC decode must see at the buffer head
  int          buffered;     // words delivered to the buffer, not yet consumed
  int          epoch;
  int          cyc;
  int          lat_lo, lat_hi;
  logic        prev_pending;
  logic [31:0] prev_addr;

  int n_vec, n_err;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negative edge; leaves the bench at the negative edge after
  // reset release, with the model restarted at the selected DUT's reset PC.
  task automatic do_reset();
    logic [31:0] start;
    start        = sel ? PC_B : PC_A;
    rst          = 1'b1;
    redirect_val = 1'b0;
    stall_D      = 1'b0;
    imemreq_rdy  = 1'b1;
    imemresp_val = 1'b0;
    #1;
    check_bit("rst_imemreq_val", o_rv, 1'b0);
    check_bit("rst_val_D", o_vd, 1'b0);
    check("rst_pc_F", o_addr, start);
    repeat (2) @(negedge clk);
    check_bit("rst_hold_val_D", o_vd, 1'b0);
    rst = 1'b0;
    mem_q.delete();
    fetch_pc     = start;
    head_pc      = start;
    buffered     = 0;
    epoch++;
    prev_pending = 1'b0;
  endtask

  // One clock cycle. Caller sets redirect/stall/rdy; the memory model drives
  // the response. Outputs are checked 1 time unit after the falling edge.
  task automatic step();
    logic exp_rv, acc, push, pop;
    req_t e;
    imemresp_val  = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imemresp_data = imemresp_val ? word(mem_q[0].addr) : 32'h0;
    #1;
    exp_rv = !redirect_val && (mem_q.size() + buffered < DEPTH);
    check_bit("imemreq_val", o_rv, exp_rv);
    if (exp_rv) check("imemreq_addr", o_addr, fetch_pc);
    if (prev_pending && !redirect_val) begin
      check_bit("hold_imemreq_val", o_rv, 1'b1);
      check("hold_imemreq_addr", o_addr, prev_addr);
    end
    check_bit("val_D", o_vd, buffered != 0);
    if (buffered != 0) begin
      check("pc_D", o_pc, head_pc);
      check("inst_D", o_inst, word(head_pc));
    end

    acc          = exp_rv && imemreq_rdy;
    prev_pending = exp_rv && !imemreq_rdy;
    prev_addr    = fetch_pc;
    push         = 1'b0;
    if (imemresp_val) begin
      e    = mem_q.pop_front();
      push = !redirect_val && (e.epoch == epoch);
    end
    pop = (buffered != 0) && !stall_D && !redirect_val;
    if (acc) begin
      mem_q.push_back('{fetch_pc, epoch, cyc + int'($urandom_range(lat_lo, lat_hi))});
      fetch_pc = fetch_pc + 32'd4;
    end
    if (redirect_val) begin
      epoch++;
      fetch_pc = redirect_pc;
      head_pc  = redirect_pc;
      buffered = 0;
    end else begin
      if (pop) head_pc = head_pc + 32'd4;
      buffered = buffered + int'(push) - int'(pop);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic found;
    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; sel = 1'b0;
    lat_lo = 1; lat_hi = 1;
    rst = 1'b1; redirect_val = 1'b0; redirect_pc = 32'h0; stall_D = 1'b0;
    imemreq_rdy = 1'b1; imemresp_val = 1'b0; imemresp_data = 32'h0;
    prev_pending = 1'b0; prev_addr = 32'h0;
    fetch_pc = PC_A; head_pc = PC_A; buffered = 0;
    @(negedge clk);

    // Streaming after reset, 1-cycle latency, always ready.
    do_reset();
    repeat (12) step();

    // Decode stalled from the start: two words fill the buffer, head frozen.
    do_reset();
    stall_D = 1'b1;
    repeat (6) step();
    #1;
    check_bit("stall_full_no_req", o_rv, 1'b0);
    check("stall_head_pc", o_pc, 32'h0000_0200);
    stall_D = 1'b0;
    repeat (8) step();

    // Memory not ready while the 0x208 request is pending.
    do_reset();
    repeat (3) step();
    imemreq_rdy = 1'b0;
    repeat (4) step();
    #1;
    check("rdy_low_addr", o_addr, 32'h0000_0208);
    imemreq_rdy = 1'b1;
    repeat (8) step();

    // Redirect with two requests in flight, 3-cycle latency.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_q.size() == 2) found = 1'b1;
      else step();
    end
    check_bit("redirect_inflight2_setup", found, 1'b1);
    redirect_val = 1'b1; redirect_pc = 32'h0000_1000;
    step();
    redirect_val = 1'b0;
    repeat (14) step();

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_q.size() != 0 && mem_q[0].due <= cyc && buffered != 0) found = 1'b1;
      else step();
    end
    check_bit("redirect_resp_pop_setup", found, 1'b1);
    redirect_val = 1'b1; redirect_pc = 32'h0000_2000;
    step();
    redirect_val = 1'b0;
    #1;
    check_bit("redirect_flush_val_D", o_vd, 1'b0);
    repeat (8) step();

    // Randomized traffic, variable latency, with one mid-run reset.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      stall_D      = ($urandom_range(0, 3) == 0);
      imemreq_rdy  = ($urandom_range(0, 3) != 0);
      redirect_val = ($urandom_range(0, 19) == 0);
      redirect_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    redirect_val = 1'b0; stall_D = 1'b0; imemreq_rdy = 1'b1;

    // Reset PC at the top of the address space: fetch wraps to zero.
    sel    = 1'b1;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
